bcd_serial_adder: RTL and testbench



---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_serial_adder.sv | 160 ++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and types for the BCD arithmetic blocks.
//   BCD_DIGIT_W  width of one packed BCD digit
//   BCD_MAX      largest legal digit value
//   BCD_CORR     correction added when a digit sum overflows past 9
//   bcd_digit_t  one packed BCD digit
//   state_t      sequencer states of the digit-serial adder
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when a digit is not a legal BCD value (A..F).
  function automatic logic digit_invalid(input bcd_digit_t d);
    return d > bcd_digit_t'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit decimal adder with correction.
//   a, b  input digits (any 4-bit value; illegal digits follow the same rule)
//   ci    decimal carry-in
//   s     corrected result digit
//   co    decimal carry-out (raw sum exceeded 9)
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);

  localparam int ZW = BCD_DIGIT_W + 1;

  logic [ZW-1:0] z;
  logic [ZW-1:0] z_corr;

  assign z      = ZW'(a) + ZW'(b) + ZW'(ci);
  // Wrap of the 5-bit corrected sum is harmless: only the low digit is kept.
  assign z_corr = z + ZW'(BCD_CORR);
  assign co     = z > ZW'(BCD_MAX);
  assign s      = co ? z_corr[BCD_DIGIT_W-1:0] : z[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial DIGITS-wide BCD adder/subtractor.
// Operands are latched on start and summed one digit per clock, LSD first,
// through a single bcd_digit_add.
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   start  request, sampled only while idle
//   sub    1 = A-B, 0 = A+B (latched with start)
//   a, b   packed BCD operands, digit 0 in [3:0]
//   ci     carry-in for addition (latched with start)
//   busy   operation in progress
//   done   one-cycle completion pulse
//   s      result, held until the next completion
//   co     decimal carry-out; in subtraction 1 = no borrow (A >= B)
//   err    an operand digit exceeded 9; updates with done, held
// Build option: define BCD_SUB_EN to enable subtraction. Without it the
// nine's-complement path is absent and every operation is A+B+ci.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sub,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          ci,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] s,
  output logic                          co,
  output logic                          err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_sr, b_sr;   // operands, current digit at [3:0]
  logic [W-1:0]     acc;          // partial result, fills from the MSB side
  logic [W-1:0]     acc_next;
  logic             carry_q;
  logic             err_pend;     // err of the operation in flight
  logic             err_any;
  logic             last;
  logic             start_carry;
  bcd_digit_t       b_eff;
  bcd_digit_t       dsum;
  logic             dco;

`ifdef BCD_SUB_EN
  logic sub_q;

  // Subtraction is A + nine's complement of B + 1 (ten's complement).
  assign b_eff       = sub_q ? bcd_digit_t'(BCD_MAX) - b_sr[BCD_DIGIT_W-1:0]
                             : b_sr[BCD_DIGIT_W-1:0];
  assign start_carry = sub ? 1'b1 : ci;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               sub_q <= 1'b0;
    else if (state_q == IDLE && start)     sub_q <= sub;
  end
`else
  logic unused_sub;

  assign unused_sub  = sub;
  assign b_eff       = b_sr[BCD_DIGIT_W-1:0];
  assign start_carry = ci;
`endif

  bcd_digit_add u_digit (
    .a  (a_sr[BCD_DIGIT_W-1:0]),
    .b  (b_eff),
    .ci (carry_q),
    .s  (dsum),
    .co (dco)
  );

  generate
    if (DIGITS == 1) begin : g_one
      assign acc_next = dsum;
    end else begin : g_many
      assign acc_next = {dsum, acc[W-1:BCD_DIGIT_W]};
    end
  endgenerate

  always_comb begin
    err_any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      err_any = err_any | digit_invalid(a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                        | digit_invalid(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

  assign last = (idx_q == IDX_W'(DIGITS - 1));

  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred even when a case arm leaves state_d untouched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      carry_q  <= 1'b0;
      err_pend <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      co       <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_sr     <= a;
          b_sr     <= b;
          acc      <= '0;
          idx_q    <= '0;
          carry_q  <= start_carry;
          err_pend <= err_any;
        end
        RUN: begin
          a_sr    <= a_sr >> BCD_DIGIT_W;
          b_sr    <= b_sr >> BCD_DIGIT_W;
          acc     <= acc_next;
          carry_q <= dco;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            s    <= acc_next;
            co   <= dco;
            err  <= err_pend;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed self-checking bench for bcd_serial_adder.
// A decimal-arithmetic model predicts busy/done/s/co/err every cycle; the
// directed vectors also carry hand-computed literal results.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, sub = 1'b0, ci = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, co, err;
  logic [W-1:0] s;

  logic         start1 = 1'b0;
  logic [3:0]   a1 = '0, b1 = '0;
  logic         busy1, done1, co1, err1;
  logic [3:0]   s1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(DIGITS)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(1'b0), .a(a1), .b(b1),
    .ci(1'b0), .busy(busy1), .done(done1), .s(s1), .co(co1), .err(err1)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0, p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  task automatic model_op(input logic [W-1:0] ma, mb, input logic msub, mci,
                          output logic [W-1:0] ms, output logic mco,
                          output logic merr);
    logic sub_eff;
    int   pw, va, vb, r, c, z, bd;
`ifdef BCD_SUB_EN
    sub_eff = msub;
`else
    sub_eff = 1'b0;
`endif
    merr = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) merr = 1'b1;
    pw = 10 ** DIGITS;
    if (!merr) begin
      va = bcd2int(ma);
      vb = bcd2int(mb);
      if (sub_eff) begin
        r   = va - vb;
        mco = (r >= 0);
        ms  = int2bcd(r >= 0 ? r : pw + r);
      end else begin
        r   = va + vb + int'(mci);
        mco = (r >= pw);
        ms  = int2bcd(r % pw);
      end
    end else begin
      // Illegal digits: apply the per-digit decimal rule directly.
      c = sub_eff ? 1 : int'(mci);
      ms = '0;
      for (int i = 0; i < DIGITS; i++) begin
        bd = int'(mb[4*i +: 4]);
        if (sub_eff) bd = (9 - bd) & 15;
        z = int'(ma[4*i +: 4]) + bd + c;
        if (z > 9) begin ms[4*i +: 4] = 4'((z + 6) & 15); c = 1; end
        else       begin ms[4*i +: 4] = 4'(z);            c = 0; end
      end
      mco = c[0];
    end
  endtask

  logic         m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_err = 1'b0;
  logic         p_co, p_err;
  logic [W-1:0] m_s = '0, p_s;
  int           m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_s = '0; m_co = 1'b0; m_err = 1'b0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == DIGITS) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_s = p_s; m_co = p_co; m_err = p_err;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        model_op(a, b, sub, ci, p_s, p_co, p_err);
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", busy, m_busy);
    check("cyc_done", done, m_done);
    check("cyc_s",    s,    m_s);
    check("cyc_co",   co,   m_co);
    check("cyc_err",  err,  m_err);
    if (done) n_done++;
  end

  // ---------------- directed stimulus ----------------
  // Call right after a negedge; start rises immediately, so back-to-back
  // calls also exercise a start in the cycle done is high.
  task automatic do_op(input logic [W-1:0] ta, tb_v, input logic tsub, tci,
                       input logic [W-1:0] es, input logic eco, eerr,
                       input string tag);
    int n;
    a = ta; b = tb_v; sub = tsub; ci = tci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, DIGITS);
    check({tag, "_s"},   s,   es);
    check({tag, "_co"},  co,  eco);
    check({tag, "_err"}, err, eerr);
  endtask

  initial begin
    int d0;
    #1 rst = 1'b1;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s",    s,    '0);
    check("rst_co",   co,   1'b0);
    check("rst_err",  err,  1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, "add_basic");
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    do_op(16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, "add_max");
`ifdef BCD_SUB_EN
    do_op(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0, "sub_pos");
`else
    do_op(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0, "sub_off");
`endif
    do_op(16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0, "sub_neg");
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, "bad_digit");
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "err_clear");

    // start pulsed while busy must be ignored: one done, first result
    @(negedge clk);
    d0 = n_done;
    a = 16'h2222; b = 16'h3333; sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (DIGITS + 3) @(negedge clk);
    check("busy_start_dones", n_done - d0, 1);
    check("busy_start_s", s, 16'h5555);

    // reset during the second RUN cycle: outputs clear, no done
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_s",    s,    '0);
    check("midrst_co",   co,   1'b0);
    d0 = n_done;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (DIGITS + 2) @(negedge clk);
    check("midrst_no_done", n_done - d0, 0);
    do_op(16'h0450, 16'h0550, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "after_rst");

    // single-digit build: done one cycle after start
    a1 = 4'h7; b1 = 4'h5; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("d1_busy", busy1, 1'b1);
    check("d1_early", done1, 1'b0);
    @(negedge clk);
    check("d1_done", done1, 1'b1);
    check("d1_s",    s1,    4'h2);
    check("d1_co",   co1,   1'b1);
    check("d1_err",  err1,  1'b0);
    @(negedge clk);
    check("d1_pulse", done1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

endmodule
